// File: rtl/wb_sprite_master_if.sv
// Wishbone classic link between the sprite-register write initiator and the
// vga_driver slave port.
interface wb_sprite_master_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_sprite_master.sv
// Buffered Wishbone single-write initiator for the VGA sprite register bank.
// Optional bus-cycle timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_sprite_master #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [3:0]          req_idx_i,
    input  logic [31:0]         req_dat_i,
    input  logic [3:0]          req_sel_i,
    input  logic                flush_gate_i,
    wb_sprite_master_if.master  wb,
    output logic                busy_o,
    output logic                err_o,
    output logic [15:0]         done_count_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_cfg_check
        $error("wb_sprite_master: parameter out of range");
    end

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    typedef enum logic [1:0] {IDLE = 2'd0, CYCLE = 2'd1, GAP = 2'd2} state_t;

    state_t      state, state_n;
    req_t        mem [FIFO_DEPTH];
    req_t        head;
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic        full, empty, push, pop;
    logic        launch, ack_done, abort, timeout;
    logic        cyc_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign req_ready_o = !full;
    assign push        = req_valid_i && !full;
    assign head        = mem[rd_ptr[AW-1:0]];
    assign pop         = ack_done || abort;
    assign wr_ptr_n    = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_ptr_n    = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{req_idx_i, req_dat_i, req_sel_i};
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic [7:0] to_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)           to_cnt <= 8'd0;
        else if (launch)           to_cnt <= 8'd0;
        else if (state == CYCLE)   to_cnt <= to_cnt + 8'd1;
    end

    // Fires on the TIMEOUT_CYCLES-th clock edge spent in CYCLE.
    assign timeout = (state == CYCLE) && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        launch   = 1'b0;
        ack_done = 1'b0;
        abort    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && flush_gate_i) begin
                    launch  = 1'b1;
                    state_n = CYCLE;
                end
            end
            CYCLE: begin
                // Ack takes priority over a simultaneous error.
                if (wb.wb_ack_i) begin
                    ack_done = 1'b1;
                    state_n  = GAP;
                end else if (wb.wb_err_i || timeout) begin
                    abort   = 1'b1;
                    state_n = GAP;
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cyc_q        <= 1'b0;
            wb.wb_adr_o  <= 32'd0;
            wb.wb_dat_o  <= 32'd0;
            wb.wb_sel_o  <= 4'd0;
            err_o        <= 1'b0;
            done_count_o <= 16'd0;
            busy_o       <= 1'b0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            busy_o <= (wr_ptr_n != rd_ptr_n) || (state_n != IDLE);
            if (launch) begin
                cyc_q       <= 1'b1;
                wb.wb_adr_o <= BASE_ADDR + {26'd0, head.idx, 2'b00};
                wb.wb_dat_o <= head.dat;
                wb.wb_sel_o <= head.sel;
            end else if (pop) begin
                cyc_q <= 1'b0;
            end
            if (abort)    err_o        <= 1'b1;
            if (ack_done) done_count_o <= done_count_o + 16'd1;
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = cyc_q;
endmodule

// File: tb/tb_wb_sprite_master.sv
// Randomized self-checking bench for wb_sprite_master with a transaction-level
// reference model and a responding Wishbone slave.
module tb_wb_sprite_master;
    localparam int          DEPTH = 4;
    localparam int          TO    = 16;
    localparam logic [31:0] BASE  = 32'h4000_0100;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_idx = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        gate = 1'b0;
    logic        ready, busy, err;
    logic [15:0] done;

    always #5 clk = ~clk;

    wb_sprite_master_if wb ();

    wb_sprite_master #(
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(ready),
        .req_idx_i(req_idx), .req_dat_i(req_dat), .req_sel_i(req_sel),
        .flush_gate_i(gate), .wb(wb),
        .busy_o(busy), .err_o(err), .done_count_o(done)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: responds after s_dly (or a random 1..3) edges of stb, can error on one index.
    int          s_dly = 1;
    bit          s_rand = 1'b0;
    bit          s_silent = 1'b0;
    bit          s_err_en = 1'b0;
    logic [3:0]  s_err_idx = 4'h2;
    int          s_cnt = 0;
    int          s_lim = 1;
    int          s_rlim = 1;
    int          s_ack_cnt = 0;
    logic        s_stb, s_ack, s_err;
    logic [3:0]  s_idx;

    always @(posedge clk) begin
        s_stb = wb.wb_stb_o;
        s_ack = wb.wb_ack_i;
        s_err = wb.wb_err_i;
        s_idx = wb.wb_adr_o[5:2];
        #1;
        s_lim = s_rand ? s_rlim : s_dly;
        if (!rst_n) s_ack_cnt = 0;
        if (!rst_n || !s_stb || s_ack || s_err) begin
            wb.wb_ack_i = 1'b0;
            wb.wb_err_i = 1'b0;
            s_cnt = 0;
        end else if (!s_silent) begin
            s_cnt++;
            if (s_cnt >= s_lim) begin
                if (s_err_en && s_idx == s_err_idx) wb.wb_err_i = 1'b1;
                else begin
                    wb.wb_ack_i = 1'b1;
                    s_ack_cnt++;
                end
                s_cnt = 0;
                s_rlim = $urandom_range(1, 3);
            end
        end
    end

    // Reference model: a queue of pending writes, at most one open bus transaction,
    // and one dead cycle after each transaction closes.
    typedef struct {
        logic [3:0]  idx;
        logic [31:0] dat;
        logic [3:0]  sel;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e;
    bit          m_push, m_open, m_dead, m_err;
    int          m_age;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic [15:0] m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_open = 0; m_dead = 0; m_err = 0; m_age = 0;
            m_adr = '0; m_dat = '0; m_sel = '0; m_done = '0;
        end else begin
            m_push = req_valid && (mq.size() < DEPTH);
            m_e = '{req_idx, req_dat, req_sel};
            if (m_open) begin
                m_age++;
                if (wb.wb_ack_i) begin
                    m_done = m_done + 16'd1;
                    void'(mq.pop_front());
                    m_open = 0; m_dead = 1;
                end else if (wb.wb_err_i || (TIMEOUT_ON && m_age == TO)) begin
                    m_err = 1;
                    void'(mq.pop_front());
                    m_open = 0; m_dead = 1;
                end
            end else if (m_dead) begin
                m_dead = 0;
            end else if (mq.size() > 0 && gate) begin
                m_open = 1; m_age = 0;
                m_adr = BASE + 32'(mq[0].idx) * 32'd4;
                m_dat = mq[0].dat;
                m_sel = mq[0].sel;
            end
            if (m_push) mq.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc", wb.wb_cyc_o, m_open);
            chk("stb", wb.wb_stb_o, m_open);
            chk("we", wb.wb_we_o, m_open);
            chk("adr", wb.wb_adr_o, m_adr);
            chk("dat", wb.wb_dat_o, m_dat);
            chk("sel", wb.wb_sel_o, m_sel);
            chk("ready", ready, mq.size() < DEPTH);
            chk("busy", busy, (mq.size() > 0) || m_open || m_dead);
            chk("err", err, m_err);
            chk("done", done, m_done);
        end
    end

    // Launch-cycle monitor for spacing checks.
    int cyc_n = 0;
    logic cyc_prev = 1'b0;
    int launch_cyc[$];
    always @(posedge clk) cyc_n++;
    always @(negedge clk) begin
        if (wb.wb_cyc_o && !cyc_prev) launch_cyc.push_back(cyc_n);
        cyc_prev = wb.wb_cyc_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] idx, input logic [31:0] dat, input logic [3:0] sel);
        logic r;
        int n = 0;
        req_valid = 1'b1; req_idx = idx; req_dat = dat; req_sel = sel;
        r = 1'b0;
        while (!r && n < 200) begin
            r = ready;
            tick();
            n++;
        end
        if (!r) chk("push_accept", 32'(r), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_cyc(input logic lvl, input int max, input string nm);
        int n = 0;
        while (wb.wb_cyc_o !== lvl && n < max) begin
            tick();
            n++;
        end
        chk(nm, wb.wb_cyc_o, lvl);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d0;
        int n;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("reset_ready", ready, 1'b1);
        chk("reset_cyc", wb.wb_cyc_o, 1'b0);
        chk("reset_adr", wb.wb_adr_o, 32'd0);
        chk("reset_done", done, 16'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // Single write, one-cycle slave: launch at N+1, two cycles of cyc.
        gate = 1'b1;
        req_valid = 1'b1; req_idx = 4'd0; req_dat = 32'h0140; req_sel = 4'h3;
        tick();
        req_valid = 1'b0;
        chk("t1_cyc_at_push", wb.wb_cyc_o, 1'b0);
        chk("t1_busy_at_push", busy, 1'b1);
        tick();
        chk("t1_cyc_n1", wb.wb_cyc_o, 1'b1);
        chk("t1_adr", wb.wb_adr_o, BASE);
        chk("t1_dat", wb.wb_dat_o, 32'h0140);
        chk("t1_sel", wb.wb_sel_o, 4'h3);
        tick();
        chk("t1_cyc_n2", wb.wb_cyc_o, 1'b1);
        tick();
        chk("t1_cyc_n3", wb.wb_cyc_o, 1'b0);
        chk("t1_done", done, 16'd1);
        tick();
        chk("t1_busy_n4", busy, 1'b0);

        // Fill with gate low, fifth request stalls, then drain at 4-cycle spacing.
        gate = 1'b0;
        push(4'd0, 32'hA000_0000, 4'hF);
        push(4'd1, 32'hA000_0001, 4'h1);
        push(4'd2, 32'hA000_0002, 4'h2);
        push(4'd3, 32'hA000_0003, 4'h4);
        chk("t2_ready_full", ready, 1'b0);
        req_valid = 1'b1; req_idx = 4'd2; req_dat = 32'hA000_0004; req_sel = 4'h8;
        tick(); tick(); tick();
        chk("t2_still_full", ready, 1'b0);
        chk("t2_no_launch", wb.wb_cyc_o, 1'b0);
        launch_cyc.delete();
        gate = 1'b1;
        n = 0;
        while (!ready && n < 50) begin tick(); n++; end
        chk("t2_slot_freed", ready, 1'b1);
        tick();
        req_valid = 1'b0;
        wait_idle(100);
        chk("t2_done", done, 16'd6);
        chk("t2_launches", launch_cyc.size(), 5);
        for (int i = 0; i + 1 < launch_cyc.size(); i++)
            chk("t2_spacing", launch_cyc[i+1] - launch_cyc[i], 4);

        // Gate drops mid-cycle: cycle finishes, nothing new until gate returns.
        s_dly = 3;
        d0 = done;
        push(4'd5, 32'h5555_0005, 4'hF);
        wait_cyc(1'b1, 5, "t3_launch");
        gate = 1'b0;
        push(4'd6, 32'h6666_0006, 4'hC);
        wait_cyc(1'b0, 10, "t3_complete");
        chk("t3_done1", done, d0 + 16'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("t3_held", wb.wb_cyc_o, 1'b0);
        chk("t3_busy_held", busy, 1'b1);
        gate = 1'b1;
        wait_idle(50);
        chk("t3_done2", done, d0 + 16'd2);
        s_dly = 1;

        // Error on idx 2: entry dropped, sticky err, following entry still issued.
        s_err_en = 1'b1; s_err_idx = 4'd2;
        d0 = done;
        push(4'd1, 32'h1111_1111, 4'hF);
        push(4'd2, 32'h2222_2222, 4'hF);
        push(4'd3, 32'h3333_3333, 4'hF);
        wait_idle(60);
        chk("t4_err", err, 1'b1);
        chk("t4_done", done, d0 + 16'd2);
        s_err_en = 1'b0;

        // Reset mid-cycle with three entries queued behind the open one.
        s_silent = 1'b1;
        push(4'd8, 32'h8888_0000, 4'hF);
        push(4'd9, 32'h9999_0000, 4'hF);
        push(4'd10, 32'hAAAA_0000, 4'hF);
        push(4'd11, 32'hBBBB_0000, 4'hF);
        chk("t6_cyc_before", wb.wb_cyc_o, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_cyc_rst", wb.wb_cyc_o, 1'b0);
        chk("t6_stb_rst", wb.wb_stb_o, 1'b0);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_done_rst", done, 16'd0);
        chk("t6_err_rst", err, 1'b0);
        chk("t6_ready_rst", ready, 1'b1);
        tick(); tick();
        rst_n = 1'b1;
        s_silent = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_launch", wb.wb_cyc_o, 1'b0);
        chk("t6_busy_after", busy, 1'b0);

        // Unresponsive slave: timeout abort or indefinite wait.
        s_silent = 1'b1;
        push(4'd7, 32'h7777_7777, 4'h5);
        wait_cyc(1'b1, 4, "t5_launch");
        n = 0;
        if (TIMEOUT_ON) begin
            while (wb.wb_cyc_o && n < 200) begin tick(); n++; end
            chk("t5_timeout_len", n, TO);
            chk("t5_timeout_err", err, 1'b1);
        end else begin
            for (int i = 0; i < 110; i++) tick();
            chk("t5_no_timeout", wb.wb_cyc_o, 1'b1);
            chk("t5_no_err", err, 1'b0);
        end
        s_silent = 1'b0;
        do_reset();

        // Randomized traffic with random gating, ack latency and errors on one index.
        s_rand = 1'b1; s_err_en = 1'b1; s_err_idx = 4'hB;
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 99) < 40);
            req_idx   = 4'($urandom_range(0, 15));
            req_dat   = $urandom();
            req_sel   = 4'($urandom_range(0, 15));
            gate      = ($urandom_range(0, 99) < 70);
            tick();
        end
        req_valid = 1'b0;
        gate = 1'b1;
        wait_idle(200);
        chk("rand_done_vs_acks", done, 16'(s_ack_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_sprite_master.md
# wb_sprite_master

Wishbone classic single-write initiator that feeds the VGA sprite register bank from game-control logic. Register writes (index, data, byte-selects) are buffered in a small FIFO and issued one bus cycle at a time. Issue is optionally gated to a frame-safe window such as vertical blank. The block sits between the game sequencer and the `vga_driver` slave port, and drives the other end of the same Wishbone link.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, 2–16.
- `TIMEOUT_CYCLES`, 16: cycles with `wb_cyc_o` high and no ack before abort; 2–255; used only with the timeout macro.
- `BASE_ADDR`, 32'h0: slave base address; `wb_adr_o` = `BASE_ADDR` + {idx, 2'b00}.

Ports:
- `wb_clk_i`, in, 1: the only clock.
- `wb_rst_n_i`, in, 1: asynchronous active-low reset.
- `req_valid_i`, in, 1: request present.
- `req_ready_o`, out, 1: FIFO not full; combinational.
- `req_idx_i`, in, 4: register index, same decode as slave `adr[5:2]`.
- `req_dat_i`, in, 32: write data.
- `req_sel_i`, in, 4: byte selects.
- `flush_gate_i`, in, 1: issue permitted when high.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, out, 1 each: bus strobes; `wb_we_o` = `wb_stb_o`.
- `wb_adr_o`, out, 32: bus address.
- `wb_dat_o`, out, 32: bus write data.
- `wb_sel_o`, out, 4: bus byte selects.
- `wb_ack_i`, in, 1: slave acknowledge.
- `wb_err_i`, in, 1: slave error.
- `busy_o`, out, 1: FIFO non-empty or FSM not IDLE.
- `err_o`, out, 1: sticky error; cleared only by reset.
- `done_count_o`, out, 16: count of acked writes; wraps.

## Operation
- FIFO push on `req_valid_i & req_ready_o` at a clock edge. `req_ready_o` = !full; a pop in the same cycle does not raise ready while full.
- FSM states are IDLE, CYCLE and GAP.
- IDLE: if the FIFO is non-empty and `flush_gate_i`=1, register the head entry onto `wb_adr_o`/`wb_dat_o`/`wb_sel_o`, assert `cyc`/`stb`/`we`, and go to CYCLE. Otherwise stay in IDLE.
- CYCLE: bus outputs are held stable. When `wb_ack_i` is sampled high:
  - drop `cyc`/`stb`/`we`;
  - pop the FIFO;
  - increment `done_count_o` (16'hFFFF wraps to 0);
  - go to GAP.
- CYCLE, on `wb_err_i` sampled high (and no ack): drop strobes, pop and discard the entry, set `err_o`, go to GAP.
- CYCLE, if ack and err are sampled high together: ack wins.
- `flush_gate_i` is sampled only in IDLE. Deasserting it during CYCLE does not abort the cycle.
- GAP: one cycle with `wb_cyc_o`=0, so a toggling slave ack clears. Then go to IDLE.
- `wb_adr_o`/`wb_dat_o`/`wb_sel_o` hold their last values outside cycles; they are 0 after reset.
- FIFO order is strict; there is no reordering or merging.

## Timing
- Reset (asynchronous, immediate) sets:
  - `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_sel_o`=0;
  - `err_o`=0, `done_count_o`=0, `busy_o`=0;
  - FIFO empty, FSM in IDLE.
- `req_ready_o`=1 while in reset.
- Reset mid-cycle drops strobes immediately and loses all pending entries.
- Latency: a push at edge N into an empty FIFO with the gate high gives `cyc`/`stb` high from edge N+1.
- Against a slave with a one-cycle registered ack:
  - ack is high in cycle N+2;
  - strobes are low from edge N+3 (GAP);
  - IDLE at N+4, next launch at edge N+5.
- Sustained issue rate is one write per 4 cycles against such a slave.
- All outputs except `req_ready_o` are registered.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined: an 8-bit counter runs in CYCLE.
  - If it reaches `TIMEOUT_CYCLES` with no ack or err, the cycle is aborted exactly like `wb_err_i`: strobes drop, the entry is discarded, `err_o` is set, FSM goes to GAP.
  - Abort happens on the `TIMEOUT_CYCLES`-th CYCLE clock.
  - The counter clears on entry to CYCLE.
- Not defined: there is no counter; CYCLE waits indefinitely for `wb_ack_i` or `wb_err_i`.

## Test plan
- Reset release, gate high, push idx=0, dat=32'h0140, sel=4'h3; slave acks 1 cycle after stb -> `wb_adr_o`=`BASE_ADDR`+0, `wb_dat_o`=32'h0140, `wb_sel_o`=4'h3, `cyc` high from push edge+1 for 2 cycles, `done_count_o`=1, `busy_o` returns to 0.
- Push 5 entries (idx 0..3, 2) back-to-back with gate low, `FIFO_DEPTH`=4 -> `req_ready_o` falls after 4th push and the 5th is held. Raise gate -> 4 writes issued in order at 4-cycle spacing; the 5th is accepted once the first pop frees a slot; final `done_count_o`=5.
- Gate drops during CYCLE with ack delayed 3 cycles -> cycle completes, no new cycle launches until gate returns.
- Slave asserts `wb_err_i` on idx=2 -> entry dropped, `err_o`=1 sticky, next entry still issued, `done_count_o` excludes it.
- With `WB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no ack -> strobes drop after 16 CYCLE clocks, `err_o`=1. Without the macro, strobes stay high for 100+ cycles.
- Assert `wb_rst_n_i` low mid-CYCLE with 3 entries queued -> strobes 0 immediately, `busy_o`=0, `done_count_o`=0; after release no cycle launches.
